// File: rtl/shift_cmd_queue_pkg.sv
// Shared definitions for the shift command queue.
// Holds the shifter mode encodings, the command entry width and the packed
// command layout {data[12:5], shift[4:2], mode[1:0]}.
package shift_cmd_queue_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  localparam int unsigned CMD_W = 13;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] shift;
    logic [1:0] mode;
  } cmd_t;

endpackage

// File: rtl/shift_cmd_queue_sync_fifo.sv
// sync_fifo: DEPTH x W synchronous FIFO with occupancy counter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push, i_wdata   write request and data (ignored while full)
//   i_pop             read request (ignored while empty)
//   o_rdata           head entry, combinational
//   o_full, o_empty   derived from the occupancy count
//   o_level           occupancy, 0..DEPTH
// Storage is not reset; only pointers and level are.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned W     = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers are AW bits wide, so DEPTH = 2**AW wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: buffers shift requests and drives an external 8-bit
// combinational shifter from the FIFO head, registering its result into a
// valid/ready output stage.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             request handshake (in_ready = !full)
//   in_data/in_shift/in_mode      request operand, amount, mode
//   sh_data/sh_shift/sh_mode      FIFO head to the shifter
//   sh_result                     shifter output (same cycle)
//   out_valid/out_ready           result handshake
//   out_data/out_err              registered result, illegal-mode flag
//   level                         FIFO occupancy
module shift_cmd_queue
  import shift_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_shift,
  input  logic [1:0]    in_mode,
  output logic [7:0]    sh_data,
  output logic [2:0]    sh_shift,
  output logic [1:0]    sh_mode,
  input  logic [7:0]    sh_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_err,
  output logic [AW:0]   level
);

  cmd_t       w_wr_cmd;
  cmd_t       w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_head_ill;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic       r_out_err;

  assign w_wr_cmd   = '{data: in_data, shift: in_shift, mode: in_mode};
  assign w_push     = in_valid && !w_full;
  assign w_pop      = !w_empty && (!r_out_valid || out_ready);
  assign w_head_ill = (w_head.mode == MODE_ILL);

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wr_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Head is masked to zero while empty so the unreset storage never leaks
  // onto the shifter inputs after reset.
  always_comb begin
    sh_data  = '0;
    sh_shift = '0;
    sh_mode  = '0;
    if (!w_empty) begin
      sh_data  = w_head.data;
      sh_shift = w_head.shift;
      sh_mode  = w_head.mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head_ill ? '0 : sh_result;
      r_out_err   <= w_head_ill;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_shift_cmd_queue.sv
module tb_shift_cmd_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shift;
  logic [1:0] in_mode;
  logic [7:0] sh_data;
  logic [2:0] sh_shift;
  logic [1:0] sh_mode;
  logic [7:0] sh_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [2:0] level;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  vec_t tbl[10];
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  shift_cmd_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .sh_data   (sh_data),
    .sh_shift  (sh_shift),
    .sh_mode   (sh_mode),
    .sh_result (sh_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .level     (level)
  );

  // Behavioural stand-in for the external shifter.
  always_comb begin
    sh_result = '0;
    case (sh_mode)
      2'b00:   sh_result = sh_data << sh_shift;
      2'b01:   sh_result = sh_data >> sh_shift;
      2'b10:   sh_result = $signed(sh_data) >>> sh_shift;
      default: sh_result = '0;
    endcase
  end

  function automatic logic [8:0] exp_fn(input logic [7:0] d, input logic [2:0] s,
                                        input logic [1:0] m);
    logic [7:0] r;
    case (m)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
      default: r = 8'h00;
    endcase
    return {(m == 2'b11), r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_shift = s;
    in_mode  = m;
  endtask

  // One cycle with scoreboard tracking of both handshakes.
  task automatic mon_tick(output logic acc_in);
    logic acc_out;
    logic [8:0] e;
    #1;
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    if (acc_out) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("stream_data", {24'd0, out_data}, {24'd0, e[7:0]});
        check("stream_err", {31'd0, out_err}, {31'd0, e[8]});
      end
    end
    if (acc_in) sb.push_back(exp_fn(in_data, in_shift, in_mode));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    logic [7:0] d;

    tbl[0] = '{8'h81, 3'd1, 2'b10, 8'hC0, 1'b0};
    tbl[1] = '{8'h01, 3'd3, 2'b00, 8'h08, 1'b0};
    tbl[2] = '{8'hF0, 3'd4, 2'b01, 8'h0F, 1'b0};
    tbl[3] = '{8'h80, 3'd7, 2'b10, 8'hFF, 1'b0};
    tbl[4] = '{8'h55, 3'd2, 2'b11, 8'h00, 1'b1};
    tbl[5] = '{8'h55, 3'd2, 2'b00, 8'h54, 1'b0};
    tbl[6] = '{8'h7F, 3'd0, 2'b10, 8'h7F, 1'b0};
    tbl[7] = '{8'hFF, 3'd7, 2'b01, 8'h01, 1'b0};
    tbl[8] = '{8'h96, 3'd5, 2'b00, 8'hC0, 1'b0};
    tbl[9] = '{8'h96, 3'd5, 2'b10, 8'hFC, 1'b0};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    #23;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_sh_data", {24'd0, sh_data}, 32'd0);
    rst = 1'b0;
    tick();

    // First-result latency: push at edge k, result visible after edge k+1.
    drive(1'b1, 8'h81, 3'd1, 2'b10);
    tick();
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    check("lat_k_valid", {31'd0, out_valid}, 32'd0);
    check("lat_k_level", {29'd0, level}, 32'd1);
    tick();
    check("lat_k1_valid", {31'd0, out_valid}, 32'd1);
    check("lat_k1_data", {24'd0, out_data}, 32'h0000_00C0);
    check("lat_k1_err", {31'd0, out_err}, 32'd0);
    check("lat_k1_level", {29'd0, level}, 32'd0);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_data_hold", {24'd0, out_data}, 32'h0000_00C0);

    // Table stream, one request per cycle, results one cycle behind.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, tbl[i].d, tbl[i].s, tbl[i].m);
      else        drive(1'b0, 8'h00, 3'd0, 2'b00);
      tick();
      if (i > 0) begin
        check($sformatf("tbl%0d_valid", i-1), {31'd0, out_valid}, 32'd1);
        check($sformatf("tbl%0d_data", i-1), {24'd0, out_data}, {24'd0, tbl[i-1].ed});
        check($sformatf("tbl%0d_err", i-1), {31'd0, out_err}, {31'd0, tbl[i-1].ee});
      end
    end
    tick();
    check("tbl_idle_level", {29'd0, level}, 32'd0);

    // Back-pressure: 1 held + 4 queued.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].d, tbl[i].s, tbl[i].m);
      #1;
      check($sformatf("bp_ready%0d", i), {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_level", {29'd0, level}, 32'd4);
    check("bp_held_valid", {31'd0, out_valid}, 32'd1);
    check("bp_held_data", {24'd0, out_data}, 32'h0000_00C0);
    tick();
    tick();
    check("bp_stable_data", {24'd0, out_data}, 32'h0000_00C0);
    check("bp_stable_err", {31'd0, out_err}, 32'd0);
    check("bp_stable_level", {29'd0, level}, 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("bp_drain%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].ed});
      check($sformatf("bp_drain%0d_err", i), {31'd0, out_err}, {31'd0, tbl[i].ee});
      check($sformatf("bp_drain%0d_level", i), {29'd0, level}, 32'(4 - i));
    end
    tick();
    check("bp_end_valid", {31'd0, out_valid}, 32'd0);

    // Full FIFO with continuous traffic; pointers wrap several times.
    out_ready = 1'b0;
    idx = 0;
    while (idx < 5) begin
      d = 8'(idx * 37 + 5);
      drive(1'b1, d, 3'(idx), 2'(idx % 4));
      mon_tick(acc);
      if (acc) idx++;
    end
    check("cont_fill_level", {29'd0, level}, 32'd4);
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      d = 8'(idx * 37 + 5);
      drive(1'b1, d, 3'(idx), 2'(idx % 4));
      mon_tick(acc);
      if (acc) idx++;
      if (c > 0) check("cont_level_steady", {31'd0, (level == 3'd3)}, 32'd1);
    end
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    for (int c = 0; c < 20 && sb.size() > 0; c++) mon_tick(acc);
    check("cont_sb_empty", sb.size(), 32'd0);
    check("cont_level_zero", {29'd0, level}, 32'd0);
    check("cont_accepted", idx, 32'd20);
    tick();

    // Reset mid-stream with 3 queued and one result held.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tbl[5].d, tbl[5].s, tbl[5].m);
      tick();
    end
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    check("pre_rst_level", {29'd0, level}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 8'h01, 3'd3, 2'b00);
    tick();
    drive(1'b0, 8'h00, 3'd0, 2'b00);
    tick();
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", {24'd0, out_data}, 32'h0000_0008);
    tick();
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    check("post_rst_level", {29'd0, level}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
